// File: rtl/dsp_boot_pkg.sv
// dsp_boot_pkg: shared definitions for the DSP0 boot sequencer.
//   - boot_state_e : FSM state encodings (also exported on the debug port)
//   - BOOT_MODE_DEFAULT : default 13-bit boot-strap value
//   - STRAP_LSB/STRAP_MSB/STRAP_W : strap bus bit indices (bit 0 = strap 1)
`timescale 1ns/1ps
package dsp_boot_pkg;

  typedef enum logic [2:0] {
    ST_POR     = 3'd0,
    ST_RSTFULL = 3'd1,
    ST_HOLD    = 3'd2,
    ST_WAIT_HB = 3'd3,
    ST_RUN     = 3'd4,
    ST_FAIL    = 3'd5
  } boot_state_e;

  localparam int STRAP_LSB = 0;
  localparam int STRAP_MSB = 12;
  localparam int STRAP_W   = STRAP_MSB - STRAP_LSB + 1;

  localparam logic [STRAP_W-1:0] BOOT_MODE_DEFAULT = 13'b101_1100000_110;

endpackage

// File: rtl/dsp_boot_seq_sync_edge_det.sv
// sync_edge_det: 2-FF synchronizer followed by a registered rising-edge pulse.
// Ports:
//   clk        in  sampling clock
//   rst        in  asynchronous active-high reset
//   async_in   in  asynchronous input
//   rise_pulse out one-cycle registered pulse per rising edge of async_in
// Latency from async_in rising to rise_pulse high: 3 clock edges.
`timescale 1ns/1ps
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic sync3_q, sync3_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    pulse_d = sync2_q & ~sync3_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
      pulse_q <= pulse_d;
    end
  end

  assign rise_pulse = pulse_q;

endmodule

// File: rtl/dsp_boot_seq.sv
// dsp_boot_seq: power-on / reset sequencer for DSP0.
// Drives PORn and RESETFULLn in order, holds the boot-strap bus at BOOT_MODE
// through reset release, then tri-states the straps and waits for a rising
// edge on the DSP heartbeat GPIO. Reports boot_ok / boot_fail as levels.
// Ports:
//   clk_sys, rst_sys     clock, asynchronous active-high reset
//   boot_req             single-cycle pulse; honoured only in RUN or FAIL,
//                        where it restarts the sequence at POR next cycle.
//                        A pulse in any other state is dropped.
//   dsp_gpio_hb          asynchronous heartbeat from the DSP
//   dsp0_porn, dsp0_resetfulln   DSP reset pins
//   strap_out, strap_oe  strap drive value and pad output enable
//   dsp0_rstn_state      1 while RESETFULLn is high
//   boot_ok, boot_fail   boot outcome levels
//   state                current FSM state (debug)
// All outputs are flops loaded from the next-state decode, so they change
// on the same edge as the state register.
`timescale 1ns/1ps
module dsp_boot_seq
  import dsp_boot_pkg::*;
#(
  parameter logic [STRAP_W-1:0] BOOT_MODE = BOOT_MODE_DEFAULT,
  parameter int T_POR     = 1000,
  parameter int T_RSTFULL = 500,
  parameter int T_HOLD    = 64,
  parameter int T_TIMEOUT = 2**20,
  parameter int CNT_W     = 21
) (
  input  logic                       clk_sys,
  input  logic                       rst_sys,
  input  logic                       boot_req,
  input  logic                       dsp_gpio_hb,
  output logic                       dsp0_porn,
  output logic                       dsp0_resetfulln,
  output logic [STRAP_MSB:STRAP_LSB] strap_out,
  output logic                       strap_oe,
  output logic                       dsp0_rstn_state,
  output logic                       boot_ok,
  output logic                       boot_fail,
  output logic [2:0]                 state
);

  localparam logic [CNT_W-1:0] POR_LAST     = CNT_W'(T_POR - 1);
  localparam logic [CNT_W-1:0] RSTFULL_LAST = CNT_W'(T_RSTFULL - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(T_TIMEOUT - 1);

  logic hb_rise;

  sync_edge_det u_hb_det (
    .clk        (clk_sys),
    .rst        (rst_sys),
    .async_in   (dsp_gpio_hb),
    .rise_pulse (hb_rise)
  );

  boot_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              porn_q, porn_d;
  logic              resetfulln_q, resetfulln_d;
  logic              strap_oe_q, strap_oe_d;
  logic [STRAP_W-1:0] strap_out_q, strap_out_d;
  logic              rstn_state_q, rstn_state_d;
  logic              boot_ok_q, boot_ok_d;
  logic              boot_fail_q, boot_fail_d;

  // Next-state and counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      ST_POR:     if (cnt_q == POR_LAST)     state_d = ST_RSTFULL;
      ST_RSTFULL: if (cnt_q == RSTFULL_LAST) state_d = ST_HOLD;
      ST_HOLD:    if (cnt_q == HOLD_LAST)    state_d = ST_WAIT_HB;
      ST_WAIT_HB: begin
        // Heartbeat takes priority over a coincident timeout.
        if (hb_rise)                     state_d = ST_RUN;
        else if (cnt_q == TIMEOUT_LAST)  state_d = ST_FAIL;
      end
      ST_RUN, ST_FAIL: begin
        cnt_d = cnt_q;  // parked; no timing needed here
        if (boot_req) state_d = ST_POR;
      end
      default: state_d = ST_POR;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Output decode from the next state.
  always_comb begin
    porn_d       = (state_d != ST_POR);
    resetfulln_d = (state_d inside {ST_HOLD, ST_WAIT_HB, ST_RUN, ST_FAIL});
    strap_oe_d   = (state_d inside {ST_POR, ST_RSTFULL, ST_HOLD});
    strap_out_d  = BOOT_MODE;
    rstn_state_d = resetfulln_d;
    boot_ok_d    = (state_d == ST_RUN);
    boot_fail_d  = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) begin
      state_q      <= ST_POR;
      cnt_q        <= '0;
      porn_q       <= 1'b0;
      resetfulln_q <= 1'b0;
      strap_oe_q   <= 1'b1;
      strap_out_q  <= BOOT_MODE;
      rstn_state_q <= 1'b0;
      boot_ok_q    <= 1'b0;
      boot_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      porn_q       <= porn_d;
      resetfulln_q <= resetfulln_d;
      strap_oe_q   <= strap_oe_d;
      strap_out_q  <= strap_out_d;
      rstn_state_q <= rstn_state_d;
      boot_ok_q    <= boot_ok_d;
      boot_fail_q  <= boot_fail_d;
    end
  end

  assign dsp0_porn       = porn_q;
  assign dsp0_resetfulln = resetfulln_q;
  assign strap_out       = strap_out_q;
  assign strap_oe        = strap_oe_q;
  assign dsp0_rstn_state = rstn_state_q;
  assign boot_ok         = boot_ok_q;
  assign boot_fail       = boot_fail_q;
  assign state           = state_q;

endmodule

// File: tb/tb_dsp_boot_seq.sv
// tb_dsp_boot_seq: directed bench for dsp_boot_seq with short timing
// parameters. The driver pushes hand-computed (cycle, output vector) events
// into exp_q; a monitor on the falling clock edge pops one entry whenever the
// output vector changes and compares both the cycle number and the value.
// Cycle N means "just after the Nth rising edge following reset release".
`timescale 1ns/1ps
module tb_dsp_boot_seq;

  localparam int OW = 22;       // {state, porn, rfn, oe, rstn_state, ok, fail, strap[12:0]}
  localparam int EW = 16 + OW;  // {cycle[15:0], outputs}

  localparam logic [2:0] S_POR = 3'd0, S_RSTFULL = 3'd1, S_HOLD = 3'd2,
                         S_WAIT = 3'd3, S_RUN = 3'd4, S_FAIL = 3'd5;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        boot_req = 1'b0;
  logic        dsp_gpio_hb = 1'b0;
  logic        dsp0_porn, dsp0_resetfulln, strap_oe, dsp0_rstn_state;
  logic        boot_ok, boot_fail;
  logic [12:0] strap_out;
  logic [2:0]  state;

  // ---------------- clock / reset block ----------------
  always #5 clk_sys = ~clk_sys;

  int cyc;
  always @(posedge clk_sys or posedge rst_sys) begin
    if (rst_sys) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  dsp_boot_seq #(
    .T_POR     (10),
    .T_RSTFULL (5),
    .T_HOLD    (4),
    .T_TIMEOUT (50),
    .CNT_W     (21)
  ) dut (
    .clk_sys         (clk_sys),
    .rst_sys         (rst_sys),
    .boot_req        (boot_req),
    .dsp_gpio_hb     (dsp_gpio_hb),
    .dsp0_porn       (dsp0_porn),
    .dsp0_resetfulln (dsp0_resetfulln),
    .strap_out       (strap_out),
    .strap_oe        (strap_oe),
    .dsp0_rstn_state (dsp0_rstn_state),
    .boot_ok         (boot_ok),
    .boot_fail       (boot_fail),
    .state           (state)
  );

  logic [OW-1:0] outs;
  assign outs = {state, dsp0_porn, dsp0_resetfulln, strap_oe, dsp0_rstn_state,
                 boot_ok, boot_fail, strap_out};

  // Hand-written output table per state; straps always 13'h1706.
  function automatic logic [OW-1:0] vec(input logic [2:0] st);
    case (st)
      S_POR:     vec = {3'd0, 6'b001000, 13'h1706};
      S_RSTFULL: vec = {3'd1, 6'b101000, 13'h1706};
      S_HOLD:    vec = {3'd2, 6'b111100, 13'h1706};
      S_WAIT:    vec = {3'd3, 6'b110100, 13'h1706};
      S_RUN:     vec = {3'd4, 6'b110110, 13'h1706};
      S_FAIL:    vec = {3'd5, 6'b110101, 13'h1706};
      default:   vec = '1;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [EW-1:0] act,
                       input logic [EW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)",
                  name, act, exp, cyc, $time);
  endtask

  task automatic expect_at(input int c, input logic [2:0] st);
    exp_q.push_back({16'(c), vec(st)});
  endtask

  logic [OW-1:0] prev_outs;
  always @(negedge clk_sys) begin
    logic [EW-1:0] e;
    if (rst_sys) begin
      prev_outs = outs;
    end else if (outs !== prev_outs) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", EW'(outs), EW'(prev_outs));
      end else begin
        e = exp_q.pop_front();
        check("event_cycle", EW'(16'(cyc)), EW'(e[EW-1:OW]));
        check("event_outputs", EW'(outs), EW'(e[OW-1:0]));
      end
      prev_outs = outs;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_to(input int n);
    while (cyc < n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_sys     = 1'b1;
    boot_req    = 1'b0;
    dsp_gpio_hb = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk_sys);
    #1;
    check("reset_outputs", EW'(outs), EW'(vec(S_POR)));
    @(posedge clk_sys);
    #2 rst_sys = 1'b0;
  endtask

  task automatic pulse_req();
    boot_req = 1'b1;
    @(posedge clk_sys);
    #1 boot_req = 1'b0;
  endtask

  task automatic end_scn();
    check("queue_empty", EW'(exp_q.size()), EW'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset release, heartbeat, reboot from RUN, second heartbeat.
    do_reset();
    expect_at(10, S_RSTFULL);
    expect_at(15, S_HOLD);
    expect_at(19, S_WAIT);
    expect_at(34, S_RUN);
    run_to(30);
    dsp_gpio_hb = 1'b1;
    run_to(40);
    expect_at(41, S_POR);
    expect_at(51, S_RSTFULL);
    expect_at(56, S_HOLD);
    expect_at(60, S_WAIT);
    expect_at(84, S_RUN);
    pulse_req();
    run_to(45);
    dsp_gpio_hb = 1'b0;
    run_to(80);
    dsp_gpio_hb = 1'b1;
    run_to(90);
    end_scn();

    // Timeout, then reboot from FAIL.
    do_reset();
    expect_at(10, S_RSTFULL);
    expect_at(15, S_HOLD);
    expect_at(19, S_WAIT);
    expect_at(69, S_FAIL);
    run_to(75);
    expect_at(76, S_POR);
    expect_at(86, S_RSTFULL);
    pulse_req();
    run_to(90);
    end_scn();

    // Heartbeat during RSTFULL and boot_req during HOLD are both ignored.
    do_reset();
    expect_at(10, S_RSTFULL);
    expect_at(15, S_HOLD);
    expect_at(19, S_WAIT);
    expect_at(69, S_FAIL);
    run_to(11);
    dsp_gpio_hb = 1'b1;
    run_to(16);
    pulse_req();
    run_to(75);
    end_scn();

    // Asynchronous reset during HOLD, then a clean restart.
    do_reset();
    expect_at(10, S_RSTFULL);
    expect_at(15, S_HOLD);
    run_to(17);
    #1 rst_sys = 1'b1;
    #1 check("async_reset_outputs", EW'(outs), EW'(vec(S_POR)));
    end_scn();
    do_reset();
    expect_at(10, S_RSTFULL);
    expect_at(15, S_HOLD);
    expect_at(19, S_WAIT);
    run_to(25);
    end_scn();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dsp_boot_seq.md
# dsp_boot_seq

Power-on and reset sequencer for DSP0. It sequences the DSP reset pins (PORn, RESETFULLn) and drives the 13-bit boot-strap bus with the configured boot mode through reset release. After the strap hold time it releases the strap bus to high-Z and waits for a GPIO heartbeat from the DSP. It reports boot success or timeout to the board logic, and its `dsp0_rstn_state` output feeds the existing GPIO/LED monitor.

## Interface
- `BOOT_MODE`, 13'b101_1100000_110, strap value driven on `strap_out[12:0]` during reset (bit 0 = strap 1).
- `T_POR`, 1000, cycles PORn held low after reset/reboot.
- `T_RSTFULL`, 500, cycles from PORn high to RESETFULLn high.
- `T_HOLD`, 64, cycles straps stay driven after RESETFULLn high.
- `T_TIMEOUT`, 2**20, cycles allowed for first heartbeat edge after strap release.
- `CNT_W`, 21, counter width; must satisfy 2**CNT_W > max of the four timing parameters.
- `clk_sys`  in  1  system clock, all logic on rising edge.
- `rst_sys`  in  1  asynchronous, active-high reset.
- `boot_req`  in  1  single-cycle pulse; restarts the sequence from the RUN or FAIL state.
- `dsp_gpio_hb`  in  1  asynchronous DSP heartbeat GPIO.
- `dsp0_porn`  out  1  DSP PORn.
- `dsp0_resetfulln`  out  1  DSP RESETFULLn.
- `strap_out`  out  13  boot-strap drive value.
- `strap_oe`  out  1  strap output enable; the pad tri-states when this is 0.
- `dsp0_rstn_state`  out  1  1 once the DSP is out of reset (RESETFULLn high).
- `boot_ok`  out  1  level; heartbeat seen.
- `boot_fail`  out  1  level; timeout expired.
- `state`  out  3  current FSM state, for debug.

## Operation
- State encodings: POR=0, RSTFULL=1, HOLD=2, WAIT_HB=3, RUN=4, FAIL=5. All outputs are registered and decoded from the state.
- **Reset values:** state POR, `dsp0_porn`=0, `dsp0_resetfulln`=0, `strap_oe`=1, `strap_out`=BOOT_MODE, `dsp0_rstn_state`=0, `boot_ok`=0, `boot_fail`=0, counter=0.
- **Counter rules:** the counter clears on every state entry. A timed state exits in the cycle where cnt==T-1, so it occupies exactly T cycles.
- **POR:** `porn`=0, `resetfulln`=0, straps driven. After T_POR cycles, go to RSTFULL.
- **RSTFULL:** `porn`=1, `resetfulln`=0, straps driven. After T_RSTFULL cycles, go to HOLD.
- **HOLD:** `resetfulln`=1, `dsp0_rstn_state`=1, straps still driven. After T_HOLD cycles, go to WAIT_HB.
- **WAIT_HB:** `strap_oe`=0, and `strap_out` keeps BOOT_MODE (don't-care).
  - A heartbeat edge goes to RUN.
  - cnt==T_TIMEOUT-1 with no edge goes to FAIL.
  - If an edge and the timeout occur in the same cycle, the edge wins and the FSM goes to RUN.
- **RUN:** `boot_ok`=1. **FAIL:** `boot_fail`=1. Both states hold until `boot_req` or reset.
- **`boot_req` handling:**
  - In RUN or FAIL, it goes to POR next cycle. All outputs return to their reset values except that the counter simply clears.
  - It is ignored in all other states.
- **Heartbeat path:** `dsp_gpio_hb` passes through a 2-FF synchronizer, then a rising-edge detector (sync2 & ~sync3).
  - The synchronizer runs in every state.
  - Only edges detected while in WAIT_HB count.
- `rst_sys` asserted mid-sequence returns the FSM to POR asynchronously and forces all outputs to their reset values immediately.

## Timing
- From `rst_sys` deassert, `dsp0_porn` rises after T_POR cycles.
- `dsp0_resetfulln` rises T_RSTFULL cycles after `dsp0_porn`.
- `strap_oe` falls T_HOLD cycles after `dsp0_resetfulln`.
- Heartbeat rising edge to `boot_ok`=1 takes 4 `clk_sys` cycles: 2 synchronizer, 1 edge register, 1 state register.
- `boot_req` to `dsp0_porn`=0 takes 1 cycle.
- Straps are never released while `resetfulln`=0.

## Structure
- Shared package `dsp_boot_pkg` holds the state encodings, the default BOOT_MODE constant and the strap bit-index constants.
- One sub-module, `sync_edge_det`: 2-FF synchronizer plus rising-edge pulse, asynchronous active-high reset. It is reused for other DSP GPIOs.

## Test plan
- Use T_POR=10, T_RSTFULL=5, T_HOLD=4, T_TIMEOUT=50 for all scenarios.
- **Reset release:** `porn` rises at cycle 10, `resetfulln` at 15, `strap_oe` falls at 19. `strap_out` stays 13'h1706 throughout.
- **Heartbeat:** heartbeat edge at cycle 30 -> `boot_ok`=1 at cycle 34, state=4, `boot_fail`=0.
- **Timeout:** no heartbeat -> `boot_fail`=1 at cycle 69, state=5. `strap_oe` stays 0.
- **Reboot:** `boot_req` in RUN -> next cycle `porn`=0, `resetfulln`=0, `strap_oe`=1, `boot_ok`=0, and the full sequence repeats with identical timing.
- **Asynchronous reset mid-sequence:** `rst_sys` pulse during HOLD -> all outputs return to reset values without waiting for a clock edge.
- **Ignored inputs:** heartbeat edge during RSTFULL and `boot_req` during HOLD -> both ignored, and the FSM timing is unchanged.
